muldiv_sequencer: RTL
=====================

# muldiv_sequencer

Multi-cycle multiply/divide controller for the CPU datapath. It sequences a single 32-bit add/subtract resource through 32 iterations to produce a 64-bit product, or a 32-bit quotient and remainder, in HI/LO form. It covers MULT, MULTU, DIV and DIVU. It sits beside the ALU in the execute stage and is driven by the control unit through a start/busy/done handshake.

## Interface
Parameters:
- WIDTH, 32, operand width; only 32 is supported.
- ITER, 32, iteration count; must equal WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset; sampled on rising edge of clk.
- start  input  1  request; accepted only in IDLE.
- op  input  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- A  input  32  multiplicand / dividend; sampled at accept edge only.
- B  input  32  multiplier / divisor; sampled at accept edge only.
- busy  output  1  high from cycle after accept until done cycle inclusive.
- done  output  1  one-cycle pulse; hi/lo/div_by_zero valid.
- hi  output  32  product[63:32] or remainder.
- lo  output  32  product[31:0] or quotient.
- div_by_zero  output  1  set with done for DIV/DIVU with B==0; cleared on next accept.

## Operation
- States: IDLE, PREP, ITER, FIX, DONE.
- IDLE, start=1: latch op, A, B; clear div_by_zero; go to PREP. IDLE, start=0: hold.
- PREP:
  - Signed ops: operands replaced by magnitude (two's complement if bit 31 set), treated as 33-bit unsigned, so 0x80000000 yields 2^31.
  - Record sign flags: quotient/product sign = A[31]^B[31]; remainder sign = A[31].
  - Clear 64-bit accumulator; load iteration counter with ITER-1; go to ITER.
- ITER, multiply (shift-add):
  - If multiplier LSB = 1, upper accumulator half += multiplicand (33-bit add, keep carry).
  - Then shift {carry, acc, multiplier} right by 1.
- ITER, divide (restoring):
  - Shift {rem, dividend} left by 1.
  - trial = rem − divisor (33-bit subtract).
  - If no borrow, rem = trial and quotient bit = 1; else rem unchanged and bit = 0.
- ITER, exit: counter decrements each cycle; when counter==0 and the iteration completes, go to FIX.
- FIX:
  - Signed ops: negate product if its sign flag is set; negate quotient / remainder by their respective sign flags.
  - Divide by zero (B==0 at accept, either signedness): force lo=0xFFFFFFFF, hi=A as latched, div_by_zero=1. Iteration results are discarded; latency is unchanged.
  - Write hi/lo; go to DONE.
- DONE: done=1, busy=1; go to IDLE unconditionally.
- Signed overflow case 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. No flag is raised.
- start outside IDLE is ignored; there is no queueing.
- hi/lo hold their last value until FIX of the next operation.
- All arithmetic is modulo 2^33 internally; outputs are truncated to 32 bits per half.

## Timing
- Accept edge = E (rising edge with IDLE & start & reset=1).
- PREP in cycle E+1; ITER cycles E+2..E+33 (32 cycles); FIX E+34; DONE E+35.
- done high exactly in cycle E+35; latency is 35 cycles for every op, including divide by zero.
- busy is high in cycles E+1..E+35. Earliest next accept edge is E+36, so back-to-back throughput is one op per 36 cycles.
- Reset (reset=0 at any edge, including mid-ITER):
  - Next state is IDLE.
  - busy=0, done=0, div_by_zero=0, hi=0, lo=0; internal accumulator and counter cleared.
  - In-flight op is abandoned.
- reset=0 and start=1 on the same edge: reset wins; nothing is accepted.
- done never coincides with accept; done and start=1 in the same cycle is ignored.

## Test plan
- MULTU A=0xFFFFFFFF B=0xFFFFFFFF -> done at E+35, hi=0xFFFFFFFE, lo=0x00000001, busy low at E+36.
- MULT A=0xFFFFFFFD (−3) B=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; MULT 0x80000000×0x80000000 -> hi=0x40000000, lo=0.
- DIVU A=100 B=7 -> lo=14, hi=2. DIV A=0xFFFFFFF9 (−7) B=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU A=0x12345678 B=0 -> at E+35 div_by_zero=1, lo=0xFFFFFFFF, hi=0x12345678. The following MULTU 2×3 clears div_by_zero and gives lo=6.
- start pulsed at E+5 with different operands during MULTU 6×7 -> ignored; result lo=42 at E+35; no second done.
- reset=0 at E+20 of a DIVU -> next cycle busy=0, hi=lo=0, no done. New DIVU 9/3 after release -> lo=3, hi=0 with full 35-cycle latency.

Source files
------------

// File: rtl/muldiv_sequencer_if.sv
// ---------------------------------------------------------------------------
// muldiv_sequencer_if
//   Handshake and data bundle between the control unit (master) and the
//   multiply/divide sequencer (slave).
//
//   start        master->slave  request, honoured only while the unit is idle
//   op           master->slave  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   A, B         master->slave  operands, sampled on the accept edge only
//   busy         slave->master  operation in flight (accept+1 .. done)
//   done         slave->master  one-cycle pulse, results valid
//   hi, lo       slave->master  product[63:32]/[31:0] or remainder/quotient
//   div_by_zero  slave->master  divide with B==0, cleared on next accept
// ---------------------------------------------------------------------------
interface muldiv_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;

  modport master (
    output start, op, A, B,
    input  busy, done, hi, lo, div_by_zero
  );

  modport slave (
    input  start, op, A, B,
    output busy, done, hi, lo, div_by_zero
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// muldiv_sequencer
//   Multi-cycle MULT/MULTU/DIV/DIVU unit for the execute stage. One shared
//   adder/subtractor is stepped through ITER iterations: shift-add for
//   multiply, restoring division for divide. Signed operations work on
//   magnitudes and fix the signs up afterwards.
//
//   Fixed latency: accept edge E, PREP E+1, ITER E+2..E+33, FIX E+34,
//   DONE (done pulse) E+35, for every op including divide by zero.
//
//   Ports:
//     clk    system clock, all state changes on the rising edge
//     reset  synchronous, active-low reset
//     bus    muldiv_sequencer_if slave modport (start/op/A/B in,
//            busy/done/hi/lo/div_by_zero out)
//
//   Parameters:
//     WIDTH  operand width (only 32 is supported)
//     ITER   iteration count, must equal WIDTH
// ---------------------------------------------------------------------------
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic                clk,
  input  logic                reset,
  muldiv_sequencer_if.slave   bus
);

  localparam int CW = $clog2(ITER);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PREP = 3'd1;
  localparam logic [2:0] S_ITER = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  // Control / operand state
  logic [2:0]       state;
  logic [1:0]       op_r;       // [1]=divide, [0]=signed
  logic [WIDTH-1:0] a_r;        // A as latched, also the div-by-zero hi value
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] opnd;       // multiplicand (mul) or divisor (div) magnitude
  logic [WIDTH-1:0] acc_hi;     // product upper half / partial remainder
  logic [WIDTH-1:0] acc_lo;     // multiplier -> product lower half / dividend -> quotient
  logic [CW-1:0]    cnt;
  logic             neg_q;      // product / quotient must be negated
  logic             neg_r;      // remainder must be negated

  // Result registers
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic             dbz_r;

  logic is_div;
  logic is_signed;
  assign is_div    = op_r[1];
  assign is_signed = op_r[0];

  // ------------------------------------------------------------------------
  // Operand magnitudes. For signed ops a negative operand is two's
  // complemented; 0x80000000 maps onto itself, which read unsigned is 2^31.
  // ------------------------------------------------------------------------
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  assign mag_a = (is_signed && a_r[WIDTH-1]) ? -a_r : a_r;
  assign mag_b = (is_signed && b_r[WIDTH-1]) ? -b_r : b_r;

  // ------------------------------------------------------------------------
  // Shared adder. Two guard bits: bit WIDTH is the multiply carry, bit
  // WIDTH+1 is the divide borrow (the subtract is done as a + ~b + 1).
  // ------------------------------------------------------------------------
  logic [WIDTH:0]   rem_sh;     // partial remainder after the left shift
  logic [WIDTH+1:0] add_a;
  logic [WIDTH+1:0] add_b;
  logic [WIDTH+1:0] sum;
  logic             no_borrow;

  assign rem_sh    = {acc_hi, acc_lo[WIDTH-1]};
  assign add_a     = is_div ? {1'b0, rem_sh} : {2'b00, acc_hi};
  assign add_b     = is_div ? ~{2'b00, opnd}
                            : (acc_lo[0] ? {2'b00, opnd} : '0);
  assign sum       = add_a + add_b + {{(WIDTH+1){1'b0}}, is_div};
  assign no_borrow = ~sum[WIDTH+1];

  // ------------------------------------------------------------------------
  // Per-iteration next accumulator values and FIX-stage results.
  // ------------------------------------------------------------------------
  logic [WIDTH-1:0]   acc_hi_nxt;
  logic [WIDTH-1:0]   acc_lo_nxt;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  always_comb begin
    // NOTE: every variable assigned here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    acc_hi_nxt = acc_hi;
    acc_lo_nxt = acc_lo;
    if (is_div) begin
      // Restoring step: keep the trial difference only if it did not borrow.
      // When it did, the shifted remainder is below the divisor and fits.
      acc_hi_nxt = no_borrow ? sum[WIDTH-1:0] : rem_sh[WIDTH-1:0];
      acc_lo_nxt = {acc_lo[WIDTH-2:0], no_borrow};
    end else begin
      // Shift {carry, acc_hi, multiplier} right by one.
      acc_hi_nxt = sum[WIDTH:1];
      acc_lo_nxt = {sum[0], acc_lo[WIDTH-1:1]};
    end
  end

  assign prod_fix = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
  assign quo_fix  = neg_q ? -acc_lo : acc_lo;
  assign rem_fix  = neg_r ? -acc_hi : acc_hi;

  // ------------------------------------------------------------------------
  // Sequencer
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!reset) begin
      state  <= S_IDLE;
      op_r   <= '0;
      a_r    <= '0;
      b_r    <= '0;
      opnd   <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      cnt    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      hi_r   <= '0;
      lo_r   <= '0;
      dbz_r  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            op_r  <= bus.op;
            a_r   <= bus.A;
            b_r   <= bus.B;
            dbz_r <= 1'b0;
            state <= S_PREP;
          end
        end

        S_PREP: begin
          // Sign flags only matter for signed ops, so fold that in here.
          neg_q  <= is_signed & (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
          neg_r  <= is_signed & a_r[WIDTH-1];
          acc_hi <= '0;
          if (is_div) begin
            acc_lo <= mag_a;
            opnd   <= mag_b;
          end else begin
            acc_lo <= mag_b;
            opnd   <= mag_a;
          end
          cnt   <= CW'(ITER - 1);
          state <= S_ITER;
        end

        S_ITER: begin
          acc_hi <= acc_hi_nxt;
          acc_lo <= acc_lo_nxt;
          cnt    <= cnt - 1'b1;
          if (cnt == '0) begin
            state <= S_FIX;
          end
        end

        S_FIX: begin
          if (is_div && (b_r == '0)) begin
            // Divide by zero: iteration results are discarded.
            hi_r  <= a_r;
            lo_r  <= '1;
            dbz_r <= 1'b1;
          end else if (is_div) begin
            hi_r <= rem_fix;
            lo_r <= quo_fix;
          end else begin
            hi_r <= prod_fix[2*WIDTH-1:WIDTH];
            lo_r <= prod_fix[WIDTH-1:0];
          end
          state <= S_DONE;
        end

        S_DONE: begin
          // start in this cycle is deliberately ignored.
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy        = (state != S_IDLE);
  assign bus.done        = (state == S_DONE);
  assign bus.hi          = hi_r;
  assign bus.lo          = lo_r;
  assign bus.div_by_zero = dbz_r;

endmodule
